// File: rtl/perf_pkg.sv
// Shared types for the performance-counter unit: measurement FSM states and
// the default read-select width.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam int DEF_NUM_EVT = 4;
    localparam int DEF_SEL_W   = $clog2(DEF_NUM_EVT + 1);

endpackage

// File: rtl/perf_cnt_cell.sv
// One live counter with sticky overflow; saturates or wraps at all-ones.
// Exposes its next value so the parent can snapshot post-increment counts.
module perf_cnt_cell #(
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (i_clr) begin
            w_cnt_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (i_inc) begin
            if (&r_cnt) begin
                w_ovf_nxt = 1'b1;
                w_cnt_nxt = (SAT_MODE != 0) ? r_cnt : '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_cnt_nxt;
    assign o_ovf     = r_ovf;

endmodule

// File: rtl/perf_counter_unit.sv
// Cycle + event performance monitor: IDLE/RUN/FROZEN FSM, auto-freeze at END_PC,
// shadow snapshot bank with a registered read port (1-cycle latency).
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int             NUM_EVT  = 4,
    parameter int             CNT_W    = 32,
    parameter int             SAT_MODE = 1,
    parameter int             PC_W     = 32,
    parameter logic [PC_W-1:0] END_PC  = 'h1c
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [PC_W-1:0]                i_pc_debug,
    input  logic                           i_cnt_en,
    input  logic [NUM_EVT-1:0]             i_evt,
    input  logic                           i_clear,
    input  logic                           i_snap,
    input  logic [$clog2(NUM_EVT+1)-1:0]   i_rd_sel,
    output logic [CNT_W-1:0]               o_rd_data,
    output logic [NUM_EVT:0]               o_ovf,
    output logic                           o_running,
    output logic                           o_done
);

    localparam int NC    = NUM_EVT + 1;
    localparam int SEL_W = $clog2(NUM_EVT + 1);

    state_t           r_state;
    logic             r_running;
    logic             r_done;
    logic [CNT_W-1:0] r_rd_data;
    logic [CNT_W-1:0] r_shadow [NC];

    logic [CNT_W-1:0] w_cnt     [NC];
    logic [CNT_W-1:0] w_cnt_nxt [NC];
    logic [NC-1:0]    w_inc;
    logic [NC-1:0]    w_ovf;
    logic             w_count;
    logic             w_end;
    logic [CNT_W-1:0] w_rd;

    // A clear cycle never counts and never freezes, even when END_PC is seen.
    assign w_count = (r_state == RUN) && !i_clear;
    assign w_end   = w_count && (i_pc_debug == END_PC);

    for (genvar k = 0; k < NC; k++) begin : g_cell
        if (k == 0) begin : g_cyc
            assign w_inc[k] = w_count;
        end else begin : g_evt
            assign w_inc[k] = w_count & i_evt[k-1];
        end
        perf_cnt_cell #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE)) u_cell (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_clr     (i_clear),
            .i_inc     (w_inc[k]),
            .o_cnt     (w_cnt[k]),
            .o_cnt_nxt (w_cnt_nxt[k]),
            .o_ovf     (w_ovf[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_end;
            if (i_clear) begin
                if (r_state == FROZEN) r_state <= IDLE;
            end else begin
                unique case (r_state)
                    IDLE: if (i_cnt_en) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                    RUN: if (i_pc_debug == END_PC) begin
                        r_state   <= FROZEN;
                        r_running <= 1'b0;
                    end else if (!i_cnt_en) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                    FROZEN: ;
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NC; k++) begin
            if (i_rd_sel == SEL_W'(k)) w_rd = r_shadow[k];
        end
    end

    // Auto-snapshot takes post-increment values; manual snap takes start-of-cycle values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
            for (int k = 0; k < NC; k++) r_shadow[k] <= '0;
        end else begin
            r_rd_data <= w_rd;
            for (int k = 0; k < NC; k++) begin
                if (w_end)       r_shadow[k] <= w_cnt_nxt[k];
                else if (i_snap) r_shadow[k] <= w_cnt[k];
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_ovf     = w_ovf;
    assign o_running = r_running;
    assign o_done    = r_done;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Drives three perf_counter_unit configurations (32-bit, 4-bit saturating,
// 4-bit wrapping) from shared stimulus and checks them against an ideal-count model.
module tb_perf_counter_unit;

    localparam int NE = 4;
    localparam logic [31:0] ENDPC = 32'h1c;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        en = 1'b0;
    logic [3:0]  evt = '0;
    logic        clear = 1'b0;
    logic        snap = 1'b0;
    logic [2:0]  sel = '0;

    logic [31:0] rd_m;
    logic [3:0]  rd_s, rd_w;
    logic [4:0]  ovf_m, ovf_s, ovf_w;
    logic        run_m, run_s, run_w, done_m, done_s, done_w;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    perf_counter_unit #(.NUM_EVT(NE), .CNT_W(32), .SAT_MODE(1)) u_main (
        .i_clk(clk), .i_reset(reset), .i_pc_debug(pc), .i_cnt_en(en), .i_evt(evt),
        .i_clear(clear), .i_snap(snap), .i_rd_sel(sel), .o_rd_data(rd_m),
        .o_ovf(ovf_m), .o_running(run_m), .o_done(done_m));

    perf_counter_unit #(.NUM_EVT(NE), .CNT_W(4), .SAT_MODE(1)) u_sat (
        .i_clk(clk), .i_reset(reset), .i_pc_debug(pc), .i_cnt_en(en), .i_evt(evt),
        .i_clear(clear), .i_snap(snap), .i_rd_sel(sel), .o_rd_data(rd_s),
        .o_ovf(ovf_s), .o_running(run_s), .o_done(done_s));

    perf_counter_unit #(.NUM_EVT(NE), .CNT_W(4), .SAT_MODE(0)) u_wrap (
        .i_clk(clk), .i_reset(reset), .i_pc_debug(pc), .i_cnt_en(en), .i_evt(evt),
        .i_clear(clear), .i_snap(snap), .i_rd_sel(sel), .o_rd_data(rd_w),
        .o_ovf(ovf_w), .o_running(run_w), .o_done(done_w));

    // Model: ideal (unbounded) counts; each configuration's view is derived from them.
    longint m_cnt [5];
    longint m_shd [5];
    longint m_rd = 0;
    int     m_state = 0;   // 0 idle, 1 run, 2 frozen
    bit     m_done = 0;
    bit     m_started = 0;

    function automatic longint view(longint t, int w, bit sat);
        longint mx = (longint'(1) << w) - 1;
        if (sat) return (t > mx) ? mx : t;
        return t & mx;
    endfunction

    function automatic logic [4:0] ovf_view(int w);
        logic [4:0] v = '0;
        longint mx = (longint'(1) << w) - 1;
        for (int k = 0; k < 5; k++) v[k] = (m_cnt[k] > mx);
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        longint old [5];
        longint nrd;
        bit     ndone;
        if (reset) begin
            for (int k = 0; k < 5; k++) begin m_cnt[k] = 0; m_shd[k] = 0; end
            m_rd = 0; m_state = 0; m_done = 0;
        end else begin
            for (int k = 0; k < 5; k++) old[k] = m_cnt[k];
            nrd = (sel <= 3'd4) ? m_shd[sel] : 0;
            ndone = 0;
            if (clear) begin
                for (int k = 0; k < 5; k++) m_cnt[k] = 0;
                if (snap) for (int k = 0; k < 5; k++) m_shd[k] = old[k];
                if (m_state == 2) m_state = 0;
            end else if (m_state == 1) begin
                m_cnt[0] = m_cnt[0] + 1;
                for (int k = 1; k < 5; k++) m_cnt[k] = m_cnt[k] + longint'(evt[k-1]);
                if (pc == ENDPC) begin
                    m_state = 2;
                    ndone = 1;
                    for (int k = 0; k < 5; k++) m_shd[k] = m_cnt[k];
                end else begin
                    if (snap) for (int k = 0; k < 5; k++) m_shd[k] = old[k];
                    if (!en) m_state = 0;
                end
            end else begin
                if (snap) for (int k = 0; k < 5; k++) m_shd[k] = old[k];
                if (m_state == 0 && en) m_state = 1;
            end
            m_rd = nrd;
            m_done = ndone;
        end
        m_started = 1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("rd_main",   rd_m,  view(m_rd, 32, 1));
            chk("rd_sat",    rd_s,  view(m_rd, 4, 1));
            chk("rd_wrap",   rd_w,  view(m_rd, 4, 0));
            chk("ovf_main",  ovf_m, ovf_view(32));
            chk("ovf_sat",   ovf_s, ovf_view(4));
            chk("ovf_wrap",  ovf_w, ovf_view(4));
            chk("running",   run_m, (m_state == 1));
            chk("done",      done_m, m_done);
            chk("done_4b",   {done_s, done_w, run_s, run_w}, {m_done, m_done, m_state == 1, m_state == 1});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("lit_reset_rd", rd_m, 0);
        chk("lit_reset_run", run_m, 0);

        // END_PC freeze after 10 counted event cycles.
        en = 1'b1; tick();
        evt = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        evt = 4'b0000; pc = ENDPC; tick();
        chk("lit_done_pulse", done_m, 1);
        chk("lit_frozen_run", run_m, 0);
        pc = '0; sel = 3'd0; tick();
        chk("lit_done_once", done_m, 0);
        chk("lit_auto_sel0", rd_m, 11);
        sel = 3'd1; tick();
        chk("lit_auto_sel1", rd_m, 10);

        // FROZEN ignores enable and events.
        for (int i = 0; i < 4; i++) begin
            en = i[0]; evt = 4'hf; tick();
        end
        evt = '0; snap = 1'b1; sel = 3'd0; tick();
        snap = 1'b0; tick();
        chk("lit_frozen_hold", rd_m, 11);
        clear = 1'b1; tick();
        clear = 1'b0; en = 1'b1; tick();
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0; tick();
        snap = 1'b1; tick();
        snap = 1'b0; tick();
        chk("lit_restart", rd_m, 4);

        // Alternating event 1, snapshot on the 20th run cycle.
        clear = 1'b1; tick();
        clear = 1'b0; en = 1'b1; tick();
        sel = 3'd2;
        for (int i = 1; i <= 20; i++) begin
            evt = (i % 2 == 1) ? 4'b0010 : 4'b0000;
            snap = (i == 20);
            tick();
        end
        snap = 1'b0; evt = '0; tick();
        chk("lit_alt_sel2", rd_m, 10);
        sel = 3'd0; tick();
        chk("lit_alt_sel0", rd_m, 19);
        chk("lit_still_run", run_m, 1);

        // Narrow counters: 20 run cycles.
        en = 1'b0; tick();
        clear = 1'b1; tick();
        clear = 1'b0; en = 1'b1; tick();
        for (int i = 0; i < 19; i++) tick();
        en = 1'b0; tick();
        snap = 1'b1; tick();
        snap = 1'b0; tick();
        chk("lit_main20", rd_m, 20);
        chk("lit_sat15", rd_s, 15);
        chk("lit_wrap4", rd_w, 4);
        chk("lit_sat_ovf0", ovf_s[0], 1);
        chk("lit_wrap_ovf0", ovf_w[0], 1);

        // Snap and clear together.
        clear = 1'b1; tick();
        chk("lit_ovf_cleared", ovf_s, 0);
        clear = 1'b0; en = 1'b1; tick();
        for (int i = 0; i < 7; i++) tick();
        snap = 1'b1; clear = 1'b1; tick();
        snap = 1'b0; clear = 1'b0; en = 1'b0; tick();
        chk("lit_snapclr_sel0", rd_m, 7);

        // Reset mid-run, then END_PC in IDLE.
        en = 1'b1; tick();
        evt = 4'hf;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1; tick();
        chk("lit_rst_rd", rd_m, 0);
        chk("lit_rst_ovf", ovf_m, 0);
        chk("lit_rst_run", run_m, 0);
        reset = 1'b0; en = 1'b0; evt = '0; pc = ENDPC; tick();
        chk("lit_idle_endpc", done_m, 0);
        pc = '0;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom % 8) != 0;
            evt   = 4'($urandom);
            pc    = (($urandom % 16) == 0) ? ENDPC : $urandom;
            snap  = ($urandom % 10) == 0;
            clear = ($urandom % 25) == 0;
            sel   = 3'($urandom % 8);
            reset = ($urandom % 400) == 0;
            tick();
        end
        reset = 1'b0; clear = 1'b0; snap = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
Synthesizable, parametrised performance-monitor block for the pipelined RV32I core. It counts cycles plus NUM_EVT per-cycle event channels, for example retired instructions, control transfers and mispredictions. It freezes automatically when the end-of-test PC is reached and exposes a snapshot bank through a registered read port. It sits beside the pipeline top and is read by the bench or by a debug/LSU-mapped register window.

Parameters:
NUM_EVT, 4, number of event channels (counter 0 is always the cycle counter)
CNT_W, 32, width of every counter
SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
PC_W, 32, width of the PC input
END_PC, 32'h1c, PC value that terminates measurement

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_pc_debug  in  PC_W  current PC
i_cnt_en  in  1  start/enable counting
i_evt  in  NUM_EVT  per-cycle event strobes, one bit per channel
i_clear  in  1  zero the live counters and overflow flags
i_snap  in  1  copy the live counters into the shadow bank
i_rd_sel  in  $clog2(NUM_EVT+1)  shadow-bank index; 0 = cycles, k = event k-1
o_rd_data  out  CNT_W  registered shadow-bank read data
o_ovf  out  NUM_EVT+1  sticky overflow flag per counter
o_running  out  1  high while in RUN
o_done  out  1  one-cycle pulse when END_PC is hit in RUN

Behaviour:
- Reset (sync, active-high) clears state to IDLE; all live counters, shadow registers, o_rd_data, o_ovf, o_done and o_running are 0. Reset has priority over everything else.
- FSM state IDLE: no counting. If i_cnt_en=1, go to RUN next cycle. The enabling cycle is not counted.
- FSM state RUN, each cycle:
  - counter 0 increments by 1;
  - counter k increments iff i_evt[k-1]=1.
  - If i_pc_debug==END_PC: that cycle's increments still apply, the state goes to FROZEN, o_done pulses high for exactly one cycle, and an automatic snapshot captures the post-increment values.
  - If i_cnt_en=0 (and no END_PC match): go to IDLE; counters hold.
- FSM state FROZEN: counters hold; i_cnt_en is ignored; leave only on i_clear (to IDLE) or reset.
- i_clear in any state: live counters and o_ovf go to 0 next cycle; no increment that cycle; FROZEN goes to IDLE, other states unchanged. The shadow bank is not cleared.
- i_snap: the shadow bank gets the live counter values as they were at the start of the cycle, i.e. the pre-clear and pre-increment values. Simultaneous i_snap and i_clear therefore capture the old values. i_snap in the same cycle as the auto-snapshot: the auto-snapshot wins.
- Overflow:
  - A counter at all-ones receiving an increment: SAT_MODE=1 holds at all-ones; SAT_MODE=0 goes to 0.
  - In both modes the counter's o_ovf bit sets and stays set until i_clear or reset.
- Read port: o_rd_data = shadow[i_rd_sel], registered, latency 1 cycle. i_rd_sel > NUM_EVT returns 0. A read in the same cycle as a snapshot returns the old shadow value.
- o_running = (state==RUN), registered.
- END_PC match in IDLE or FROZEN has no effect.

Decomposition:
- perf_pkg: state enum (IDLE, RUN, FROZEN) and a localparam for the select width.
- One sub-module, perf_cnt_cell: a single CNT_W counter with inc, clr and SAT_MODE handling plus a sticky ovf bit. Instantiate it NUM_EVT+1 times with a generate loop.
- The top level holds the FSM, END_PC compare, shadow bank and read mux.

Test Plan:
1. Reset, i_cnt_en=1 for 1 cycle, i_evt=4'b0001 for 10 RUN cycles, then END_PC on the 11th RUN cycle -> o_done pulses once; snapshot: sel0=11, sel1=10 (if i_evt[0] also high on cycle 11: 11); o_running=0 afterwards.
2. Run with i_evt[1] high on alternate cycles for 20 cycles, i_snap at cycle 20 -> next cycle sel2=10 is readable with 1-cycle latency; live counting continues.
3. CNT_W=4, SAT_MODE=1, 20 cycles of RUN -> sel0=15, o_ovf[0]=1. Repeat with SAT_MODE=0 -> sel0=20 mod 16=4, o_ovf[0]=1.
4. Same-cycle i_snap and i_clear with cycle counter=7 -> shadow sel0=7; live counter 0 next cycle=0; o_ovf cleared.
5. Assert i_reset mid-RUN with counters non-zero -> next cycle all counters, shadow, o_rd_data and o_ovf are 0; state IDLE; END_PC presented in IDLE gives no o_done.
6. In FROZEN, toggle i_cnt_en and i_evt -> counters unchanged; i_clear returns the FSM to IDLE and a new i_cnt_en restarts counting from 0.
